// File: rtl/eth_header_parser_if.sv
// Byte-stream bus for eth_header_parser: the pcap replay source side
// (available/datavalid/data/newpkt/pause) and the payload FIFO output side.
interface eth_header_parser_if;
    logic       available;
    logic       datavalid;
    logic [7:0] data;
    logic       newpkt;
    logic       pause;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_sop;
    logic       out_eop;
    logic       out_ready;

    modport slave (
        input  available, datavalid, data, newpkt, out_ready,
        output pause, out_valid, out_data, out_sop, out_eop
    );
    modport master (
        output available, datavalid, data, newpkt, out_ready,
        input  pause, out_valid, out_data, out_sop, out_eop
    );
endinterface

// File: rtl/eth_header_parser.sv
// Ethernet header parser: extracts dst/src MAC and ethertype, forwards payload
// through a FWFT FIFO. Optional 802.1Q tag stripping under `VLAN_STRIP_EN`.
module eth_header_parser #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic               CLOCK,
    input  logic               RESET_N,
    eth_header_parser_if.slave bus,
    output logic               hdr_valid,
    output logic [47:0]        dst_mac,
    output logic [47:0]        src_mac,
    output logic [15:0]        ethertype,
    output logic               err_runt,
    output logic               err_abort,
    output logic               overflow,
    output logic [CNT_W-1:0]   frame_count,
    output logic [CNT_W-1:0]   runt_count
`ifdef VLAN_STRIP_EN
    ,
    output logic               vlan_present,
    output logic [15:0]        vlan_tci
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    // The final header byte is taken straight from the bus, so it is never stored.
`ifdef VLAN_STRIP_EN
    localparam int HB = 17;
`else
    localparam int HB = 13;
`endif

    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

    state_t             state_q, state_d;
    logic [4:0]         bidx_q, bidx_d;
    logic               avail_q;
    logic               stb, last;
    logic               hdr_done, runt, abort, push, vlan_tag;
    logic [HB-1:0][7:0] hdr_q;
    logic               hdr_valid_q, err_runt_q, err_abort_q, sop_q;
    logic [47:0]        dst_q, src_q;
    logic [15:0]        et_q;
    logic [CNT_W-1:0]   frame_cnt_q, runt_cnt_q;
`ifdef VLAN_STRIP_EN
    logic               vp_q;
    logic [15:0]        tci_q;
`endif

    // datavalid is sticky at the source, so a byte also needs the frame window.
    assign stb  = bus.datavalid & ~bus.newpkt & (bus.available | avail_q);
    assign last = stb & ~bus.available & avail_q;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            bidx_q  <= '0;
        end else begin
            state_q <= state_d;
            bidx_q  <= bidx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bidx_d  = bidx_q;
        if (bus.newpkt) begin
            state_d = HDR;
            bidx_d  = '0;
        end else begin
            if (stb) bidx_d = (bidx_q == 5'd31) ? bidx_q : bidx_q + 5'd1;
            case (state_q)
                HDR: begin
                    if (hdr_done)  state_d = last ? IDLE : PAYLOAD;
                    else if (last) state_d = IDLE;
                end
                PAYLOAD: if (last) state_d = IDLE;
                default: ;
            endcase
        end
    end

    always_comb begin
        vlan_tag = 1'b0;
`ifdef VLAN_STRIP_EN
        vlan_tag = (bidx_q == 5'd13) ? ({hdr_q[12], bus.data} == 16'h8100)
                                     : ({hdr_q[12], hdr_q[13]} == 16'h8100);
`endif
        hdr_done = (state_q == HDR) & stb &
                   (((bidx_q == 5'd13) & ~vlan_tag) | ((bidx_q == 5'd17) & vlan_tag));
        runt     = (state_q == HDR) & last & ~hdr_done;
        abort    = bus.newpkt & (state_q != IDLE);
        push     = (state_q == PAYLOAD) & stb;
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            avail_q     <= 1'b0;
            hdr_q       <= '0;
            hdr_valid_q <= 1'b0;
            err_runt_q  <= 1'b0;
            err_abort_q <= 1'b0;
            dst_q       <= '0;
            src_q       <= '0;
            et_q        <= '0;
            frame_cnt_q <= '0;
            runt_cnt_q  <= '0;
`ifdef VLAN_STRIP_EN
            vp_q        <= 1'b0;
            tci_q       <= '0;
`endif
        end else begin
            avail_q     <= bus.available;
            hdr_valid_q <= hdr_done;
            err_runt_q  <= runt;
            err_abort_q <= abort;
            if ((state_q == HDR) && stb)
                for (int i = 0; i < HB; i++)
                    if (bidx_q == 5'(i)) hdr_q[i] <= bus.data;
            if (hdr_done) begin
                dst_q       <= {hdr_q[0], hdr_q[1], hdr_q[2], hdr_q[3], hdr_q[4], hdr_q[5]};
                src_q       <= {hdr_q[6], hdr_q[7], hdr_q[8], hdr_q[9], hdr_q[10], hdr_q[11]};
                frame_cnt_q <= frame_cnt_q + 1'b1;
`ifdef VLAN_STRIP_EN
                vp_q <= vlan_tag;
                if (vlan_tag) begin
                    tci_q <= {hdr_q[14], hdr_q[15]};
                    et_q  <= {hdr_q[16], bus.data};
                end else begin
                    tci_q <= '0;
                    et_q  <= {hdr_q[12], bus.data};
                end
`else
                et_q <= {hdr_q[12], bus.data};
`endif
            end
            if (runt) runt_cnt_q <= runt_cnt_q + 1'b1;
        end
    end

    // Payload FIFO, entries are {eop, sop, data}.
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          full, rd, wr, pause_q, ovf_q;

    assign full          = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign bus.out_valid = (cnt_q != '0);
    assign rd            = bus.out_valid & bus.out_ready;
    assign wr            = push & (~full | rd);

    always_comb begin
        cnt_d = cnt_q;
        if (wr && !rd)      cnt_d = cnt_q + 1'b1;
        else if (rd && !wr) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge CLOCK) begin
        if (wr) mem_q[wr_ptr_q] <= {last, sop_q, bus.data};
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            pause_q  <= 1'b0;
            ovf_q    <= 1'b0;
            sop_q    <= 1'b0;
        end else begin
            if (wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd) rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q   <= cnt_d;
            // Two entries of slack cover the source's one-cycle reaction time.
            pause_q <= (cnt_d >= (AW+1)'(FIFO_DEPTH - 2));
            if (push && full && !rd) ovf_q <= 1'b1;
            if (hdr_done)  sop_q <= 1'b1;
            else if (push) sop_q <= 1'b0;
        end
    end

    assign {bus.out_eop, bus.out_sop, bus.out_data} = bus.out_valid ? mem_q[rd_ptr_q] : 10'd0;
    assign bus.pause   = pause_q;
    assign hdr_valid   = hdr_valid_q;
    assign dst_mac     = dst_q;
    assign src_mac     = src_q;
    assign ethertype   = et_q;
    assign err_runt    = err_runt_q;
    assign err_abort   = err_abort_q;
    assign overflow    = ovf_q;
    assign frame_count = frame_cnt_q;
    assign runt_count  = runt_cnt_q;
`ifdef VLAN_STRIP_EN
    assign vlan_present = vp_q;
    assign vlan_tci     = tci_q;
`endif

endmodule

// File: tb/tb_eth_header_parser.sv
// Bench for eth_header_parser: table of frames plus backpressure, abort and
// reset sequences; payload bytes are checked against a scoreboard queue.
module tb_eth_header_parser;

    localparam int CNT_W = 16;

    logic             CLOCK = 1'b0;
    logic             RESET_N;
    logic             hdr_valid, err_runt, err_abort, overflow;
    logic [47:0]      dst_mac, src_mac;
    logic [15:0]      ethertype;
    logic [CNT_W-1:0] frame_count, runt_count;
`ifdef VLAN_STRIP_EN
    logic             vlan_present;
    logic [15:0]      vlan_tci;
`endif

    eth_header_parser_if bus();

    eth_header_parser #(.FIFO_DEPTH(16), .CNT_W(CNT_W)) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .bus(bus),
        .hdr_valid(hdr_valid), .dst_mac(dst_mac), .src_mac(src_mac),
        .ethertype(ethertype), .err_runt(err_runt), .err_abort(err_abort),
        .overflow(overflow), .frame_count(frame_count), .runt_count(runt_count)
`ifdef VLAN_STRIP_EN
        , .vlan_present(vlan_present), .vlan_tci(vlan_tci)
`endif
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        int          len;
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] et;
        logic [15:0] tci;
        logic [15:0] inner;
        int          exp_hdr;
        int          exp_runt;
        int          exp_pay;
        logic [15:0] exp_et;
        logic        exp_vp;
        logic [15:0] exp_tci;
    } vec_t;

    int         n_chk = 0, n_fail = 0;
    int         hdr_seen = 0, runt_seen = 0, abort_seen = 0, out_seen = 0;
    int         pause_seen = 0, pause_qsz = -1;
    logic [9:0] sb[$];
    logic [7:0] fbuf [0:255];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Output monitor: events counted, payload popped from the scoreboard.
    always @(negedge CLOCK) begin
        if (RESET_N) begin
            if (hdr_valid) hdr_seen++;
            if (err_runt)  runt_seen++;
            if (err_abort) abort_seen++;
            if (bus.pause && pause_seen == 0) begin
                pause_seen = 1;
                pause_qsz  = sb.size();
            end
            if (bus.out_valid && bus.out_ready) begin
                out_seen++;
                if (sb.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL payload_unexpected: got %0h expected none", bus.out_data);
                end else begin
                    chk("payload", 64'({bus.out_sop, bus.out_eop, bus.out_data}), 64'(sb.pop_front()));
                end
            end
        end
    end

    task automatic fill(input vec_t v);
        logic [7:0] hb [0:17];
        for (int i = 0; i < 6; i++) begin
            hb[i]   = v.dst[47-8*i -: 8];
            hb[6+i] = v.src[47-8*i -: 8];
        end
        hb[12] = v.et[15:8];    hb[13] = v.et[7:0];
        hb[14] = v.tci[15:8];   hb[15] = v.tci[7:0];
        hb[16] = v.inner[15:8]; hb[17] = v.inner[7:0];
        for (int i = 0; i < v.len; i++) begin
            fbuf[i] = 8'(i*5 + 3);
            if (i < 14 || (i < 18 && v.et == 16'h8100)) fbuf[i] = hb[i];
        end
    endtask

    // Drive one frame; cut>0 stops after cut bytes without ending the frame.
    task automatic send(input int len, input int pay, input int cut);
        int n = (cut > 0) ? cut : len;
        int i = 0;
        int guard = 0;
        @(posedge CLOCK); #1;
        bus.newpkt = 1'b1; bus.available = 1'b1; bus.datavalid = 1'b0;
        while (i < n) begin
            @(posedge CLOCK); #1;
            bus.newpkt = 1'b0;
            if (bus.pause) begin
                bus.datavalid = 1'b0;
                guard++;
                if (guard > 2000) begin
                    n_chk++; n_fail++;
                    $display("FAIL pause_timeout: got pause stuck expected release");
                    break;
                end
            end else begin
                bus.datavalid = 1'b1;
                bus.data      = fbuf[i];
                bus.available = (cut > 0) || (i != len - 1);
                if (pay > 0 && i >= len - pay)
                    sb.push_back({(i == len - pay), (i == len - 1), fbuf[i]});
                i++;
            end
        end
        @(posedge CLOCK); #1;
        if (cut > 0) bus.datavalid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(posedge CLOCK);
            t++;
        end
        repeat (3) @(posedge CLOCK);
        #1;
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    localparam int NV = 8;
    vec_t        vt [NV];
    vec_t        v;
    int          h0, r0, o0, a0, exp_frames, exp_runts;
    logic [47:0] h_dst, h_src;
    logic [15:0] h_et, h_tci;
    logic        h_vp;

    initial begin
        vt[0] = '{60, 48'h001122334455, 48'h66778899AABB, 16'h0800, 16'h0, 16'h0, 1, 0, 46, 16'h0800, 1'b0, 16'h0};
        vt[1] = '{10, 48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 16'h0800, 16'h0, 16'h0, 0, 1, 0, 16'h0, 1'b0, 16'h0};
        vt[2] = '{14, 48'h0A0B0C0D0E0F, 48'h101112131415, 16'h88B5, 16'h0, 16'h0, 1, 0, 0, 16'h88B5, 1'b0, 16'h0};
`ifdef VLAN_STRIP_EN
        vt[3] = '{64, 48'hFFFFFFFFFFFF, 48'h020000000001, 16'h8100, 16'h6064, 16'h0806, 1, 0, 46, 16'h0806, 1'b1, 16'h6064};
        vt[4] = '{16, 48'h111111111111, 48'h222222222222, 16'h8100, 16'h0123, 16'h0800, 0, 1, 0, 16'h0, 1'b0, 16'h0};
`else
        vt[3] = '{64, 48'hFFFFFFFFFFFF, 48'h020000000001, 16'h8100, 16'h6064, 16'h0806, 1, 0, 50, 16'h8100, 1'b0, 16'h0};
        vt[4] = '{16, 48'h111111111111, 48'h222222222222, 16'h8100, 16'h0123, 16'h0800, 1, 0, 2, 16'h8100, 1'b0, 16'h0};
`endif
        vt[5] = '{15, 48'h5A5A5A5A5A5A, 48'hA5A5A5A5A5A5, 16'h86DD, 16'h0, 16'h0, 1, 0, 1, 16'h86DD, 1'b0, 16'h0};
        vt[6] = '{13, 48'h010203040506, 48'h070809101112, 16'h0800, 16'h0, 16'h0, 0, 1, 0, 16'h0, 1'b0, 16'h0};
        vt[7] = '{1,  48'h0, 48'h0, 16'h0, 16'h0, 16'h0, 0, 1, 0, 16'h0, 1'b0, 16'h0};

        RESET_N = 1'b0;
        bus.available = 1'b0; bus.datavalid = 1'b0; bus.data = 8'h00;
        bus.newpkt = 1'b0; bus.out_ready = 1'b1;
        repeat (3) @(posedge CLOCK);
        #1;
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_pause", 64'(bus.pause), 64'd0);
        chk("reset_hdr_valid", 64'(hdr_valid), 64'd0);
        chk("reset_frame_count", 64'(frame_count), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        RESET_N = 1'b1;
        repeat (2) @(posedge CLOCK);

        exp_frames = 0; exp_runts = 0;
        h_dst = '0; h_src = '0; h_et = '0; h_vp = 1'b0; h_tci = '0;
        for (int k = 0; k < NV; k++) begin
            fill(vt[k]);
            h0 = hdr_seen; r0 = runt_seen; o0 = out_seen;
            send(vt[k].len, vt[k].exp_pay, 0);
            drain();
            if (vt[k].exp_hdr != 0) begin
                h_dst = vt[k].dst; h_src = vt[k].src; h_et = vt[k].exp_et;
                h_vp = vt[k].exp_vp; h_tci = vt[k].exp_tci;
            end
            exp_frames += vt[k].exp_hdr;
            exp_runts  += vt[k].exp_runt;
            chk($sformatf("row%0d_hdr_pulses", k), 64'(hdr_seen - h0), 64'(vt[k].exp_hdr));
            chk($sformatf("row%0d_runt_pulses", k), 64'(runt_seen - r0), 64'(vt[k].exp_runt));
            chk($sformatf("row%0d_payload_bytes", k), 64'(out_seen - o0), 64'(vt[k].exp_pay));
            chk($sformatf("row%0d_dst_mac", k), 64'(dst_mac), 64'(h_dst));
            chk($sformatf("row%0d_src_mac", k), 64'(src_mac), 64'(h_src));
            chk($sformatf("row%0d_ethertype", k), 64'(ethertype), 64'(h_et));
            chk($sformatf("row%0d_frame_count", k), 64'(frame_count), 64'(exp_frames));
            chk($sformatf("row%0d_runt_count", k), 64'(runt_count), 64'(exp_runts));
`ifdef VLAN_STRIP_EN
            chk($sformatf("row%0d_vlan_present", k), 64'(vlan_present), 64'(h_vp));
            chk($sformatf("row%0d_vlan_tci", k), 64'(vlan_tci), 64'(h_tci));
`endif
        end

        // Backpressure: consumer stalls 40 cycles on a 100-byte frame.
        v = vt[0]; v.len = 100;
        fill(v);
        o0 = out_seen; pause_seen = 0; pause_qsz = -1;
        fork
            begin
                bus.out_ready = 1'b0;
                repeat (40) @(posedge CLOCK);
                #1 bus.out_ready = 1'b1;
            end
            send(100, 86, 0);
        join
        drain();
        exp_frames++;
        chk("bp_pause_seen", 64'(pause_seen), 64'd1);
        chk("bp_count_at_pause", 64'(pause_qsz), 64'd14);
        chk("bp_overflow", 64'(overflow), 64'd0);
        chk("bp_payload_bytes", 64'(out_seen - o0), 64'd86);
        chk("bp_frame_count", 64'(frame_count), 64'(exp_frames));

        // Aborts: newpkt mid-header, then newpkt mid-payload.
        fill(vt[0]);
        a0 = abort_seen; h0 = hdr_seen; o0 = out_seen;
        send(60, 0, 5);
        send(60, 46, 20);
        send(60, 46, 0);
        drain();
        exp_frames += 2;
        chk("abort_pulses", 64'(abort_seen - a0), 64'd2);
        chk("abort_hdr_pulses", 64'(hdr_seen - h0), 64'd2);
        chk("abort_payload_bytes", 64'(out_seen - o0), 64'(6 + 46));
        chk("abort_frame_count", 64'(frame_count), 64'(exp_frames));

        // Reset mid-payload, stray bytes without newpkt, then a clean frame.
        fill(vt[2]);
        send(14, 0, 0);
        fill(vt[0]);
        send(60, 46, 25);
        RESET_N = 1'b0;
        bus.available = 1'b0;
        sb.delete();
        @(posedge CLOCK); #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_dst_mac", 64'(dst_mac), 64'd0);
        chk("rst_ethertype", 64'(ethertype), 64'd0);
        chk("rst_frame_count", 64'(frame_count), 64'd0);
        chk("rst_runt_count", 64'(runt_count), 64'd0);
        chk("rst_pause", 64'(bus.pause), 64'd0);
        RESET_N = 1'b1;
        h0 = hdr_seen; r0 = runt_seen; o0 = out_seen;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLOCK); #1;
            bus.available = (i < 5); bus.datavalid = 1'b1; bus.data = 8'(8'hA0 + i);
        end
        repeat (4) @(posedge CLOCK); #1;
        chk("stray_hdr", 64'(hdr_seen - h0), 64'd0);
        chk("stray_runt", 64'(runt_seen - r0), 64'd0);
        chk("stray_out", 64'(out_seen - o0 + int'(bus.out_valid)), 64'd0);
        send(60, 46, 0);
        drain();
        chk("post_rst_frame_count", 64'(frame_count), 64'd1);
        chk("post_rst_dst_mac", 64'(dst_mac), 64'h001122334455);
        chk("post_rst_ethertype", 64'(ethertype), 64'h0800);
        chk("post_rst_payload_bytes", 64'(out_seen - o0), 64'd46);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
